// File: rtl/reg_scoreboard_pkg.sv
// Shared register-scoreboard parameters and flush-recovery FSM encoding.
package reg_scoreboard_pkg;

    localparam int unsigned NREG   = 16;
    localparam int unsigned NAME_W = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        RESUME = 2'd2
    } sb_state_e;

endpackage

// File: rtl/reg_scoreboard_sb_hazard.sv
// Combinational RAW/WAW hazard check against the busy vector; a same-cycle
// writeback releases its register because the register file writes before read.
module sb_hazard #(
    parameter int unsigned NREG   = 16,
    parameter int unsigned NAME_W = 4
) (
    input  logic [NREG-1:0]   busy_i,
    input  logic [NAME_W-1:0] issue_rd_i,
    input  logic [NAME_W-1:0] issue_rs_i,
    input  logic              issue_rd_use_i,
    input  logic              issue_rs_use_i,
    input  logic              issue_wb_i,
    input  logic              wb_v_i,
    input  logic [NAME_W-1:0] wb_rd_i,
    output logic              hazard_o
);

    logic [NREG-1:0] busy_eff;

    always_comb begin
        busy_eff = busy_i;
        if (wb_v_i) begin
            busy_eff[wb_rd_i] = 1'b0;
        end
        // rd is checked both as a read source and as a WAW target
        hazard_o = ((issue_rd_use_i | issue_wb_i) & busy_eff[issue_rd_i])
                 | (issue_rs_use_i & busy_eff[issue_rs_i]);
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard with flush drain/refetch FSM.
// Define SCOREBOARD_STATS_EN to add the saturating stall_cnt_o counter.
module reg_scoreboard #(
    parameter int unsigned NREG   = reg_scoreboard_pkg::NREG,
    parameter int unsigned NAME_W = reg_scoreboard_pkg::NAME_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_v_i,
    input  logic [NAME_W-1:0] issue_rd_i,
    input  logic [NAME_W-1:0] issue_rs_i,
    input  logic              issue_rd_use_i,
    input  logic              issue_rs_use_i,
    input  logic              issue_wb_i,
    input  logic              wb_v_i,
    input  logic [NAME_W-1:0] wb_rd_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              issue_ok_o,
    output logic [NREG-1:0]   busy_o
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [15:0]       stall_cnt_o
`endif
);

    import reg_scoreboard_pkg::*;

    sb_state_e       state_q, state_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            hazard;
    logic            stall, issue_ok;

    sb_hazard #(
        .NREG   (NREG),
        .NAME_W (NAME_W)
    ) u_hazard (
        .busy_i         (busy_q),
        .issue_rd_i     (issue_rd_i),
        .issue_rs_i     (issue_rs_i),
        .issue_rd_use_i (issue_rd_use_i),
        .issue_rs_use_i (issue_rs_use_i),
        .issue_wb_i     (issue_wb_i),
        .wb_v_i         (wb_v_i),
        .wb_rd_i        (wb_rd_i),
        .hazard_o       (hazard)
    );

    always_comb begin
        // gating with rst keeps both outputs low while reset is held
        stall    = rst & issue_v_i & (hazard | (state_q != RUN));
        issue_ok = rst & issue_v_i & ~stall & ~flush_i;

        busy_d = busy_q;
        if (wb_v_i) begin
            busy_d[wb_rd_i] = 1'b0;
        end
        if (issue_ok & issue_wb_i) begin
            busy_d[issue_rd_i] = 1'b1;
        end

        state_d = state_q;
        case (state_q)
            RUN: begin
                if (flush_i) begin
                    state_d = ((busy_q == '0) && !wb_v_i) ? RESUME : DRAIN;
                end
            end
            DRAIN:   if (busy_d == '0) state_d = RESUME;
            RESUME:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

    assign stall_o    = stall;
    assign issue_ok_o = issue_ok;
    assign busy_o     = busy_q;

`ifdef SCOREBOARD_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
